// File: rtl/seq_101_tx.sv
// seq_101_tx: serial frame transmitter for the 101 sequence-detect link.
// Each frame on the line is the preamble 1,0,1, then WIDTH payload bits MSB
// first, then a single 0 stop bit. The line idles at 0.
// Optional macro SEQ_101_TX_STUFF_EN: inserts a 0 whenever the last two line
// bits are 1,0 and the next payload bit is 1. With it, 101 can appear on the
// line only as a preamble.
module seq_101_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             data_out,
    output logic             frame_start,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, PRE, DATA, STOP} state_t;

    // r_state names the bit that is on the line now. Each edge decides the
    // next line bit, which keeps every output registered.
    state_t           r_state;
    logic [1:0]       r_pcnt;
    logic [CW-1:0]    r_bcnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_data_out;
    logic             r_frame_start;
    logic             r_frame_done;
    logic             w_msb;
    logic             w_stuff;

    assign w_msb = r_shift[WIDTH-1];

`ifdef SEQ_101_TX_STUFF_EN
    // r_hist holds the last two line bits, with the older bit in [1].
    logic [1:0] r_hist;
    assign w_stuff = (r_hist == 2'b10) && w_msb;
`else
    assign w_stuff = 1'b0;
`endif

    assign tx_ready    = (r_state == IDLE);
    assign data_out    = r_data_out;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;

    // Frame FSM: handshake, preamble, payload with optional stuffing, stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pcnt        <= '0;
            r_bcnt        <= '0;
            r_shift       <= '0;
            r_data_out    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
`ifdef SEQ_101_TX_STUFF_EN
            r_hist        <= '0;
`endif
        end else begin
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_data_out <= 1'b0;
                    if (tx_valid) begin
                        r_shift       <= tx_data;
                        r_pcnt        <= '0;
                        r_bcnt        <= '0;
                        r_data_out    <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_state       <= PRE;
                    end
                end
                PRE: begin
                    if (r_pcnt == 2'd2) begin
                        // The preamble ends with 0,1, so the history would
                        // be 01. That value can never trigger a stuff, so
                        // the first payload bit always goes out directly.
                        r_data_out <= w_msb;
                        r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bcnt     <= ONE;
                        r_state    <= DATA;
`ifdef SEQ_101_TX_STUFF_EN
                        r_hist     <= {1'b1, w_msb};
`endif
                    end else begin
                        // The preamble bit after position 0 is 0 and the
                        // bit after position 1 is 1.
                        r_data_out <= r_pcnt[0];
                        r_pcnt     <= r_pcnt + 2'd1;
                    end
                end
                DATA: begin
                    if (r_bcnt == LAST) begin
                        r_data_out   <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= STOP;
                    end else if (w_stuff) begin
                        // Send an inserted 0. The payload bit is held for
                        // the next cycle.
                        r_data_out <= 1'b0;
`ifdef SEQ_101_TX_STUFF_EN
                        r_hist     <= 2'b00;
`endif
                    end else begin
                        r_data_out <= w_msb;
                        r_shift    <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bcnt     <= r_bcnt + ONE;
`ifdef SEQ_101_TX_STUFF_EN
                        r_hist     <= {r_hist[0], w_msb};
`endif
                    end
                end
                STOP: begin
                    r_data_out <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_data_out <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_101_tx.sv
// Testbench for seq_101_tx. A reference queue of expected line cycles is
// built from the frame rules for each accepted word. Inputs are randomized.
module tb_seq_101_tx;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_ready;
    logic         data_out;
    logic         frame_start;
    logic         frame_done;

    int n_vec   = 0;
    int n_err   = 0;
    int acc_cnt = 0;
    int hits    = 0;
    logic [2:0] det = 3'b000;

    // Each entry is one expected line cycle: {bit, frame_start, frame_done}.
    logic [2:0] exp_q[$];

    seq_101_tx #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .data_out(data_out),
        .frame_start(frame_start), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line for one word. The preamble comes first, then the payload
    // MSB first. With stuffing enabled, a 0 is inserted whenever the last two
    // emitted bits are 1,0 and the next payload bit is 1. The stop bit ends
    // the frame.
    task automatic push_frame(input logic [W-1:0] w);
        bit p1, p0;
        int i;
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b100);
        p1 = 1'b0;
        p0 = 1'b1;
        i  = W - 1;
        while (i >= 0) begin
`ifdef SEQ_101_TX_STUFF_EN
            if (p1 && !p0 && w[i]) begin
                exp_q.push_back(3'b000);
                p1 = 1'b0;
                p0 = 1'b0;
                continue;
            end
`endif
            exp_q.push_back({w[i], 2'b00});
            p1 = p0;
            p0 = w[i];
            i--;
        end
        exp_q.push_back(3'b001);
    endtask

    // Monitor: on each falling edge, compare the DUT against the expected
    // cycle. When the model is idle and tx_valid is high, the word is taken
    // at the next rising edge.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst) begin
            chk("rst_dout", {31'd0, data_out}, 32'd0);
            chk("rst_fs", {31'd0, frame_start}, 32'd0);
            chk("rst_fd", {31'd0, frame_done}, 32'd0);
            chk("rst_ready", {31'd0, tx_ready}, 32'd1);
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("line", {31'd0, data_out}, {31'd0, e[2]});
            chk("frame_start", {31'd0, frame_start}, {31'd0, e[1]});
            chk("frame_done", {31'd0, frame_done}, {31'd0, e[0]});
            chk("busy_ready", {31'd0, tx_ready}, 32'd0);
        end else begin
            chk("idle_dout", {31'd0, data_out}, 32'd0);
            chk("idle_fs", {31'd0, frame_start}, 32'd0);
            chk("idle_fd", {31'd0, frame_done}, 32'd0);
            chk("idle_ready", {31'd0, tx_ready}, 32'd1);
            if (tx_valid) begin
                push_frame(tx_data);
                acc_cnt++;
            end
        end
    end

    // Independent 101 detector on the observed line
    always @(negedge clk) begin
        det = {det[1:0], data_out};
        if (det == 3'b101) hits++;
    end

    // Present a word and wait until it is taken. With hold set, tx_valid
    // stays high afterwards. tx_data is scrambled once the word is taken.
    task automatic send(input logic [W-1:0] w, input bit hold);
        int a0;
        int t;
        a0 = acc_cnt;
        t  = 0;
        tx_valid = 1'b1;
        tx_data  = w;
        while (acc_cnt == a0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (acc_cnt == a0) chk("accept_timeout", 32'd0, 32'd1);
        if (!hold) tx_valid = 1'b0;
        tx_data = W'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            tx_data = W'($urandom);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] line;
        int flen;
        logic [15:0] want;
        int a0;

        // Reset with tx_valid high, which must be ignored, then idle
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        repeat (2) @(posedge clk);
        #1 tx_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        idle_cycles(10);
        chk("no_accept_in_reset", acc_cnt, 32'd0);

        // Known-answer frame for A5, captured from the line
`ifdef SEQ_101_TX_STUFF_EN
        flen = 14;
        want = 16'b00_1011_0010_0100_10;
`else
        flen = 12;
        want = 16'b0000_1011_0100_1010;
`endif
        send(8'hA5, 1'b0);
        line = '0;
        for (int k = 0; k < flen; k++) begin
            @(negedge clk);
            line = {line[14:0], data_out};
        end
        chk("kat_a5_line", {16'd0, line}, {16'd0, want});
        chk("kat_a5_done", {31'd0, frame_done}, 32'd1);
        @(negedge clk);
        chk("kat_a5_ready_after", {31'd0, tx_ready}, 32'd1);
        drain();

        // Back-to-back with tx_valid held high: FF then 55
        a0 = acc_cnt;
        send(8'hFF, 1'b1);
        send(8'h55, 1'b0);
        drain();
        chk("b2b_frames", acc_cnt - a0, 32'd2);

        // Backpressure: tx_data keeps changing while the frame is on the line
        send(8'h96, 1'b0);
        idle_cycles(16);
        drain();

        // Reset at the 4th payload bit
        send(8'h6B, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_mid_dout", {31'd0, data_out}, 32'd0);
        chk("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(2);
        send(8'hC3, 1'b0);
        drain();

        // Randomized traffic: random words, random hold/gap, and scrambled
        // tx_data whenever the sender is not offering a word
        for (int n = 0; n < 40; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            send(W'($urandom), hold);
            if (!hold) idle_cycles($urandom_range(0, 3));
        end
        tx_valid = 1'b0;
        drain();
        idle_cycles(3);

`ifdef SEQ_101_TX_STUFF_EN
        // Each started frame reached its preamble, and stuffing keeps 101
        // out of every payload, so there is exactly one hit per frame.
        chk("detector_hits", hits, acc_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_101_tx.md
# seq_101_tx

Serial frame transmitter, the sending end of the 101 sequence-detect link. Accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a one-bit line, MSB first. Each frame is a `1,0,1` sync preamble, the payload, and one `0` stop bit. An optional zero-insertion scheme ensures that the downstream 101 detector fires only on the preamble.

## Interface
- `WIDTH`, default 8: payload bits per frame, at least 2.
- `clk`  input  1: single clock; all logic rising-edge.
- `rst`  input  1: asynchronous, active-high reset.
- `tx_valid`  input  1: `tx_data` holds a word to send.
- `tx_data`  input  WIDTH: payload; sampled on handshake.
- `tx_ready`  output  1: block can accept a word; high only in IDLE.
- `data_out`  output  1: serial line, registered; `0` when idle.
- `frame_start`  output  1: one-cycle pulse, coincident with the first preamble bit on `data_out`.
- `frame_done`  output  1: one-cycle pulse, coincident with the stop bit on `data_out`.

## Operation
- Handshake: transfer occurs on a rising edge where `tx_valid && tx_ready`. `tx_data` is copied into an internal shift register. `tx_valid` without `tx_ready` is held off, with no loss or duplication.
- FSM states: IDLE, PRE, DATA, STOP.
  - IDLE -> PRE on handshake.
  - PRE drives `1,0,1` over 3 cycles (2-bit counter), then -> DATA.
  - DATA drives payload MSB first; a bit counter of width $clog2(WIDTH+1) counts sent payload bits. After WIDTH payload bits -> STOP.
  - STOP drives `0` for 1 cycle, then -> IDLE.
- `tx_ready = (state == IDLE)`. No acceptance in PRE, DATA or STOP.
- History register `hist[1:0]` holds the last two bits driven on `data_out`. It is loaded with `01` at the end of the preamble and updated every DATA cycle.
- Stuffing (see Configuration): in DATA, if `hist == 2'b10` and the next payload bit is `1`:
  - drive `0`; the bit counter and shift register do not advance;
  - `hist` becomes `00`, so two consecutive stuffs are impossible.
- The stop bit is always `0`, never stuffed. It guarantees that a following preamble cannot form a spurious 101 with the tail of the previous frame.
- Reset values:
  - state IDLE, `data_out` = 0, `tx_ready` = 1;
  - `frame_start` = 0, `frame_done` = 0;
  - counters and `hist` = 0;
  - the shift register contents are don't-care.
- Reset mid-frame aborts the frame immediately; `data_out` drops to 0. No partial frame resumes after reset.
- `tx_valid` asserted during reset: ignored, no handshake.

## Timing
- Handshake on edge N: `data_out` = 1 and `frame_start` = 1 during cycle N+1.
- Preamble occupies cycles N+1 to N+3. Payload starts at N+4.
- Without stuffing, the stop bit is at N+4+WIDTH. With stuffing, add S cycles, where S is the number of stuffed zeros.
- `frame_done` is high during the stop cycle. `tx_ready` returns high the next cycle.
- Minimum handshake-to-handshake period: WIDTH+5 cycles (1 idle accept cycle, 3 preamble, WIDTH payload, 1 stop).
- `tx_ready` is a combinational decode of registered state; `data_out`, `frame_start` and `frame_done` are registered.

## Configuration
- `SEQ_101_TX_STUFF_EN`
  - Defined: zero-insertion is active as described. The line never contains `101` outside a preamble, so frame length varies by S, where 0 <= S <= WIDTH/2.
  - Undefined: no stuffing logic or `hist` register. Frame length is fixed at WIDTH+4 line cycles. A payload may contain `101`.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` for 3 cycles, release, hold `tx_valid`=0 for 10 cycles.
  - Required: `data_out`=0, `tx_ready`=1, no pulses.
- Basic frame, stuffing off, WIDTH=8, `tx_data`=8'hA5:
  - Required line: `1 0 1 1 0 1 0 0 1 0 1 0`.
  - `frame_start` at cycle N+1, `frame_done` at cycle N+12, `tx_ready` high again at N+13.
- Stuffing on, `tx_data`=8'hA5:
  - Required line: `1 0 1 1 0 0 1 0 0 1 0 0 1 0` (S=2, 14 cycles).
  - A 101 detector on `data_out` fires exactly once.
- Back-to-back, stuffing on:
  - Stimulus: `tx_valid` held high with 8'hFF then 8'h55.
  - Required: the second handshake occurs the cycle after the first `frame_done`; no data loss; exactly two detector hits.
- Backpressure:
  - Stimulus: change `tx_data` while `tx_ready`=0 mid-frame.
  - Required: the line carries only the originally accepted word.
- Reset mid-payload:
  - Stimulus: assert `rst` at the 4th payload bit.
  - Required: `data_out`=0 immediately; IDLE with `tx_ready`=1 after release; the next frame is well-formed.
